// File: rtl/uart_tx_if.sv
// Byte-request / serial-line bundle between a byte producer and the UART transmitter.
interface uart_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_busy;

    modport master (
        output tx_start,
        output tx_data,
        input  tx,
        input  tx_busy
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx,
        output tx_busy
    );
endinterface

// File: rtl/uart_tx.sv
// 8-N-1 UART transmitter with a fixed number of clocks per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx #(
    parameter int CLK_PER_BIT = 10416
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus
);

    localparam int CW = $clog2(CLK_PER_BIT);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          busy_q;
    logic          bitLast;

    assign bitLast     = (cnt_q == CW'(CLK_PER_BIT - 1));
    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;

    // tx and tx_busy are loaded with the value of the state being entered, so
    // they change on the same edge as the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (bus.tx_start) begin
                        shift_q <= bus.tx_data;
                        cnt_q   <= '0;
                        state_q <= START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (bitLast) begin
                        cnt_q   <= '0;
                        idx_q   <= 3'd0;
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bitLast) begin
                        cnt_q <= '0;
                        if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= ^shift_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            tx_q  <= shift_q[idx_q + 3'd1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bitLast) begin
                        cnt_q   <= '0;
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bitLast) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx, run with a short bit period.
// Frame length follows UART_TX_PARITY_EN so the same bench covers both builds.
module tb_uart_tx;

    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    uart_tx_if bus ();

    uart_tx #(.CLK_PER_BIT(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic stepClk(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected line level for frame bit position pos (0 = start bit).
    function automatic logic expBit(input logic [7:0] b, input int pos);
        logic r;
        r = 1'b1;
        if (pos == 0) r = 1'b0;
        else if (pos <= 8) r = b[pos-1];
`ifdef UART_TX_PARITY_EN
        else if (pos == 9) r = ^b;
`endif
        return r;
    endfunction

    task automatic applyStimulus(input logic [7:0] data);
        bus.tx_data  = data;
        bus.tx_start = 1'b1;
        stepClk(1);
    endtask

    // Checks every cycle of a frame that started on the previous edge; optionally
    // drives tx_data/tx_start at cycle injectAt to probe the busy-time behaviour.
    task automatic checkFrame(input string tag, input logic [7:0] b, input int injectAt,
                              input logic [7:0] injectData, input bit holdStart);
        for (int k = 0; k < FRAME_BITS * N; k++) begin
            checkOutput($sformatf("%s_tx_c%0d", tag, k), {7'd0, bus.tx}, {7'd0, expBit(b, k / N)});
            checkOutput($sformatf("%s_busy_c%0d", tag, k), {7'd0, bus.tx_busy}, 8'd1);
            if (k == 0 && !holdStart) bus.tx_start = 1'b0;
            if (k == injectAt) begin
                bus.tx_data = injectData;
                if (!holdStart) bus.tx_start = 1'b1;
            end
            if (k == injectAt + 1 && !holdStart) bus.tx_start = 1'b0;
            stepClk(1);
        end
        checkOutput({tag, "_end_tx"}, {7'd0, bus.tx}, 8'd1);
        checkOutput({tag, "_end_busy"}, {7'd0, bus.tx_busy}, 8'd0);
    endtask

    task automatic checkIdle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_tx_%0d", tag, i), {7'd0, bus.tx}, 8'd1);
            checkOutput($sformatf("%s_busy_%0d", tag, i), {7'd0, bus.tx_busy}, 8'd0);
            stepClk(1);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;

        $display("[TB] reset hold");
        for (int i = 0; i < 10; i++) begin
            stepClk(1);
            checkOutput("rst_tx", {7'd0, bus.tx}, 8'd1);
            checkOutput("rst_busy", {7'd0, bus.tx_busy}, 8'd0);
        end
        rst = 1'b0;
        stepClk(1);
        checkIdle("post_rst", 50);

        $display("[TB] 0x55 with ignored 0xFF request in DATA");
        applyStimulus(8'h55);
        checkFrame("f55", 8'h55, 2 * N + 1, 8'hFF, 1'b0);
        checkIdle("after55", 3 * N);

        $display("[TB] 0xA3 after idle");
        stepClk(50);
        applyStimulus(8'hA3);
        checkFrame("fA3", 8'hA3, -1, 8'h00, 1'b0);
        checkIdle("afterA3", 2 * N);

        $display("[TB] back-to-back with held start");
        applyStimulus(8'h00);
        checkFrame("f00", 8'h00, 1, 8'h81, 1'b1);
        stepClk(1);
        checkFrame("f81", 8'h81, -1, 8'h00, 1'b0);
        checkIdle("after81", 2 * N);

        $display("[TB] 0x07 full frame, then reset during data bit 3");
        applyStimulus(8'h07);
        checkFrame("f07", 8'h07, -1, 8'h00, 1'b0);
        stepClk(2);
        applyStimulus(8'h07);
        bus.tx_start = 1'b0;
        stepClk(4 * N + 1);
        checkOutput("bit3_tx", {7'd0, bus.tx}, 8'd0);
        checkOutput("bit3_busy", {7'd0, bus.tx_busy}, 8'd1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_tx", {7'd0, bus.tx}, 8'd1);
        checkOutput("async_rst_busy", {7'd0, bus.tx_busy}, 8'd0);
        stepClk(3);
        rst = 1'b0;
        checkIdle("no_resume", 12 * N);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
